// File: rtl/serial_mag_comparator.sv
// Purpose : bit-serial N-bit magnitude comparator. Takes one g/e/s code per
//           accepted cycle, MSB first; the first non-equal bit decides the result.
// Latency : done pulses N+1 cycles after the accepted start, plus one cycle per stall.
// Backpr. : busy doubles as the bit-code ready. A cycle with bit_valid low is a
//           stall: nothing changes and there is no timeout.
// Ports   : clk, rst_n (async, active low)
//           start         begin an operation (honoured in IDLE or DONE only)
//           bit_valid     g_in/e_in/s_in carry a bit code this cycle
//           g_in/e_in/s_in one-hot bit code: a>b / a==b / a<b
//           busy          high while bits are being consumed
//           done          one-cycle pulse when gt/eq/lt become valid
//           gt/eq/lt      word result, held until the next accepted start
//           code_err      a non-one-hot code was accepted in this operation
module serial_mag_comparator #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic g_in,
  input  logic e_in,
  input  logic s_in,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt,
  output logic code_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          pend_gt;
  logic          pend_lt;

  // Code decode. Only a legal one-hot code can decide the result.
  logic code_legal;
  logic code_g;
  logic code_s;
  logic last_bit;

  assign code_legal = (g_in ^ e_in ^ s_in) & ~(g_in & e_in & s_in);
  assign code_g     = code_legal & g_in;
  assign code_s     = code_legal & s_in;
  assign last_bit   = (cnt == LAST_IDX);

  // The pending result includes the bit being accepted this cycle. This lets
  // the final edge register a word result that already accounts for bit N.
  logic nxt_gt;
  logic nxt_lt;
  logic nxt_err;

  assign nxt_gt  = pend_gt | (~decided & code_g);
  assign nxt_lt  = pend_lt | (~decided & code_s);
  assign nxt_err = code_err | ~code_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      decided  <= 1'b0;
      pend_gt  <= 1'b0;
      pend_lt  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      code_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for start acceptance. A restart can
        // therefore coincide with the done pulse and leave no idle gap.
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            decided  <= 1'b0;
            pend_gt  <= 1'b0;
            pend_lt  <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            code_err <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          // start is deliberately ignored here.
          if (bit_valid) begin
            code_err <= nxt_err;
            // An illegal code still counts as a bit but never decides.
            if (!decided && (code_g || code_s)) begin
              decided <= 1'b1;
              pend_gt <= code_g;
              pend_lt <= code_s;
            end
            if (last_bit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              cnt   <= '0;
              // A corrupted stream yields no verdict at all.
              gt    <= nxt_gt & ~nxt_err;
              lt    <= nxt_lt & ~nxt_err;
              eq    <= ~nxt_gt & ~nxt_lt & ~nxt_err;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic g_in = 1'b0;
  logic e_in = 1'b0;
  logic s_in = 1'b0;
  logic busy, done, gt, eq, lt, code_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // res = {gt, eq, lt, code_err}; due = cycle in which done must be high
  typedef struct {
    logic [3:0] res;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  serial_mag_comparator #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .g_in(g_in), .e_in(e_in), .s_in(s_in),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .code_err(code_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result_gt_eq_lt_err", 64'({gt, eq, lt, code_err}), 64'(mon_e.res));
        check("done_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
    prev_done = done;
  end

  // Entered with time just after a posedge; returns in the DONE cycle.
  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input int nstall,
                         input int bad_pos, input logic [2:0] bad_code,
                         input bit start_in_run);
    exp_t e;
    int rem;
    int n_here;
    logic [2:0] c;
    e.due = cyc + 1 + N + nstall;
    if (bad_pos >= 0)  e.res = 4'b0001;
    else if (a > b)    e.res = 4'b1000;
    else if (a == b)   e.res = 4'b0100;
    else               e.res = 4'b0010;
    sb.push_back(e);

    start = 1'b1;
    bit_valid = 1'b0;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_in_run", 64'(busy), 64'd1);
    check("cleared_at_start", 64'({gt, eq, lt, code_err}), 64'd0);

    rem = nstall;
    for (int i = 0; i < N; i++) begin
      n_here = (i == N - 1) ? rem : int'($urandom_range(0, rem));
      for (int k = 0; k < n_here; k++) begin
        bit_valid = 1'b0;
        {g_in, e_in, s_in} = 3'($urandom);
        tick();
      end
      rem -= n_here;
      if (a[N-1-i] && !b[N-1-i])      c = 3'b100;
      else if (!a[N-1-i] && b[N-1-i]) c = 3'b001;
      else                            c = 3'b010;
      if (i == bad_pos) c = bad_code;
      {g_in, e_in, s_in} = c;
      bit_valid = 1'b1;
      start = start_in_run && (i == 2);
      tick();
    end
    bit_valid = 1'b0;
    start = 1'b0;
    {g_in, e_in, s_in} = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset_state", 64'({busy, done, gt, eq, lt, code_err}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Equal operands: done at start+9, eq held afterwards.
    send_op(8'hA5, 8'hA5, 0, -1, 3'b000, 1'b0);
    tick();
    tick();
    check("eq_held", 64'({gt, eq, lt}), 64'b010);

    // Decided at MSB; later s codes must not flip it.
    send_op(8'h80, 8'h7F, 0, -1, 3'b000, 1'b0);
    tick();
    // Bits offered while idle are ignored.
    bit_valid = 1'b1;
    {g_in, e_in, s_in} = 3'b001;
    repeat (3) tick();
    bit_valid = 1'b0;
    check("idle_not_busy", 64'(busy), 64'd0);
    check("gt_held", 64'({gt, eq, lt, code_err}), 64'b1000);

    // Five stall cycles, then back-to-back restart in the DONE cycle.
    send_op(8'h3C, 8'h3D, 5, -1, 3'b000, 1'b0);
    send_op(8'h01, 8'h00, 0, -1, 3'b000, 1'b0);
    tick();

    // Illegal code in an otherwise-equal stream, then a clean operation.
    send_op(8'h66, 8'h66, 0, 3, 3'b110, 1'b0);
    tick();
    check("err_held", 64'({gt, eq, lt, code_err}), 64'b0001);
    send_op(8'h55, 8'h55, 0, -1, 3'b000, 1'b0);
    tick();
    send_op(8'hF0, 8'h0F, 1, 5, 3'b000, 1'b0);
    tick();
    send_op(8'h0F, 8'hF0, 0, 7, 3'b111, 1'b0);
    tick();

    // Asynchronous reset mid-operation while bit 4 is on the inputs.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {g_in, e_in, s_in} = 3'b010;
      bit_valid = 1'b1;
      tick();
    end
    {g_in, e_in, s_in} = 3'b100;
    #3;
    check("busy_before_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({busy, done, gt, eq, lt, code_err}), 64'd0);
    bit_valid = 1'b0;
    tick();
    tick();
    check("reset_held_outputs", 64'({busy, done, gt, eq, lt, code_err}), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // start pulse during RUN must be ignored.
    send_op(8'h12, 8'h34, 2, -1, 3'b000, 1'b1);
    tick();
    send_op(8'hFE, 8'hFF, 0, -1, 3'b000, 1'b0);
    tick();

    for (int w = 0; w < 30 && sb.size() != 0; w++) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
